// File: rtl/cl_frame_packer.sv
// Camera Link capture: packs 80-bit samples LSB-first into 128-bit FIFO words,
// bracketing every captured frame with a header and a trailer word.
module cl_frame_packer #(
    parameter logic [31:0] HDR_MAGIC = 32'hCAFE_F00D,
    parameter logic [31:0] TRL_MAGIC = 32'hE0F0_E0F0,
    parameter int          LINE_W    = 16
) (
    input  logic         cl_clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         cl_fval,
    input  logic         cl_lval,
    input  logic [79:0]  cl_data,
    input  logic         fpga_msg_overflow,
    output logic [127:0] fpga_msg,
    output logic         fpga_msg_valid,
    output logic         frame_done,
    output logic         overflow_sticky
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_TRAILER
    } state_t;

    state_t              r_state;
    state_t              w_state_n;
    logic                r_fval;
    logic                r_fval_d;
    logic                r_lval;
    logic                r_lval_d;
    logic                r_en;
    logic [79:0]         r_data;
    logic [127:0]        r_acc;
    logic [6:0]          r_cnt;
    logic [LINE_W-1:0]   r_lines;
    logic [31:0]         r_samples;
    logic [31:0]         r_frame_no;
    logic                r_drop;
    logic [127:0]        r_msg;
    logic                r_valid;
    logic                r_done;
    logic                r_sticky;

    logic [127:0]        w_acc_n;
    logic [6:0]          w_cnt_n;
    logic [LINE_W-1:0]   w_lines_n;
    logic [31:0]         w_samples_n;
    logic [31:0]         w_frame_n;
    logic                w_drop_n;
    logic [127:0]        w_msg_n;
    logic                w_valid_n;
    logic                w_done_n;
    logic                w_accept;

    logic                w_rise;
    logic                w_sample;
    logic                w_lfall;
    logic                w_wr_ovf;
    logic                w_drop;
    logic [7:0]          w_sum;
    logic [255:0]        w_wide;
    logic [15:0]         w_lines16;

    assign w_rise    = r_fval & ~r_fval_d;
    assign w_sample  = r_fval & r_lval;
    assign w_lfall   = r_fval & r_lval_d & ~r_lval;
    assign w_wr_ovf  = r_valid & fpga_msg_overflow;
    assign w_drop    = r_drop | w_wr_ovf;
    assign w_sum     = {1'b0, r_cnt} + 8'd80;
    assign w_wide    = ({176'b0, r_data} << r_cnt) | {128'b0, r_acc};
    assign w_lines16 = 16'(r_lines);

    always_comb begin
        w_state_n   = r_state;
        w_acc_n     = r_acc;
        w_cnt_n     = r_cnt;
        w_lines_n   = r_lines;
        w_samples_n = r_samples;
        w_frame_n   = r_frame_no;
        w_drop_n    = w_drop;
        w_msg_n     = r_msg;
        w_valid_n   = 1'b0;
        w_done_n    = 1'b0;
        w_accept    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_rise && r_en) begin
                    w_state_n   = S_CAPTURE;
                    w_msg_n     = {HDR_MAGIC, r_frame_no, 64'b0};
                    w_valid_n   = 1'b1;
                    w_acc_n     = '0;
                    w_cnt_n     = '0;
                    w_lines_n   = '0;
                    w_samples_n = '0;
                    w_drop_n    = 1'b0;
                    w_accept    = w_sample;
                end
            end
            S_CAPTURE: begin
                // The fval fall cycle doubles as the flush step, so two low
                // cycles are enough to re-arm for the next frame.
                if (!r_fval) begin
                    if (r_cnt != 7'd0) begin
                        w_msg_n   = r_acc;
                        w_valid_n = 1'b1;
                    end
                    w_state_n = S_TRAILER;
                end else begin
                    w_accept = w_sample;
                    if (w_lfall && (r_lines != {LINE_W{1'b1}}))
                        w_lines_n = r_lines + LINE_W'(1);
                end
            end
            S_TRAILER: begin
                w_msg_n     = {TRL_MAGIC, r_frame_no, w_lines16,
                               15'b0, w_drop, r_samples};
                w_valid_n   = 1'b1;
                w_done_n    = 1'b1;
                w_frame_n   = r_frame_no + 32'd1;
                w_acc_n     = '0;
                w_cnt_n     = '0;
                w_lines_n   = '0;
                w_samples_n = '0;
                w_state_n   = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
        if (w_accept) begin
            w_samples_n = w_samples_n + 32'd1;
            w_cnt_n     = w_sum[6:0];
            if (w_sum[7]) begin
                w_msg_n   = w_wide[127:0];
                w_valid_n = 1'b1;
                w_acc_n   = w_wide[255:128];
            end else begin
                w_acc_n   = w_wide[127:0];
            end
        end
    end

    // fval history resets high so a frame already in flight is never joined.
    always_ff @(posedge cl_clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_fval     <= 1'b1;
            r_fval_d   <= 1'b1;
            r_lval     <= 1'b0;
            r_lval_d   <= 1'b0;
            r_en       <= 1'b0;
            r_data     <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_lines    <= '0;
            r_samples  <= '0;
            r_frame_no <= '0;
            r_drop     <= 1'b0;
            r_msg      <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_sticky   <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_fval     <= cl_fval;
            r_fval_d   <= r_fval;
            r_lval     <= cl_lval;
            r_lval_d   <= r_lval;
            r_en       <= enable;
            r_data     <= cl_data;
            r_acc      <= w_acc_n;
            r_cnt      <= w_cnt_n;
            r_lines    <= w_lines_n;
            r_samples  <= w_samples_n;
            r_frame_no <= w_frame_n;
            r_drop     <= w_drop_n;
            r_msg      <= w_msg_n;
            r_valid    <= w_valid_n;
            r_done     <= w_done_n;
            r_sticky   <= r_sticky | w_wr_ovf;
        end
    end

    assign fpga_msg        = r_msg;
    assign fpga_msg_valid  = r_valid;
    assign frame_done      = r_done;
    assign overflow_sticky = r_sticky;

endmodule

// File: tb/tb_cl_frame_packer.sv
// Scoreboard bench for cl_frame_packer: stimulus pushes expected words,
// a negedge monitor pops and compares every written word.
module tb_cl_frame_packer;

    localparam logic [31:0] HDR = 32'hCAFE_F00D;
    localparam logic [31:0] TRL = 32'hE0F0_E0F0;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         fval;
    logic         lval;
    logic [79:0]  data;
    logic         ovf;
    logic [127:0] msg;
    logic         msg_valid;
    logic         done;
    logic         sticky;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] fn_m    = 32'd0;
    bit          ovf_arm = 1'b0;
    bit          ovf_hit = 1'b0;

    typedef struct {
        logic [127:0] msg;
        logic         done;
        string        tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    cl_frame_packer dut (
        .cl_clk            (clk),
        .reset             (rst_n),
        .enable            (enable),
        .cl_fval           (fval),
        .cl_lval           (lval),
        .cl_data           (data),
        .fpga_msg_overflow (ovf),
        .fpga_msg          (msg),
        .fpga_msg_valid    (msg_valid),
        .frame_done        (done),
        .overflow_sticky   (sticky)
    );

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, want);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n === 1'b1) begin
            if (msg_valid) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %h required none", msg);
                end else begin
                    e = sb.pop_front();
                    chk({e.tag, "_msg"}, msg, e.msg);
                    chk({e.tag, "_done"}, 128'(done), 128'(e.done));
                end
            end else if (done) begin
                n_tests++;
                n_fail++;
                $display("FAIL done_alone: got frame_done=1 required 0");
            end
        end
    end

    function automatic logic [79:0] smp(input int k);
        logic [3:0] n;
        n = 4'(k);
        return {20{n}};
    endfunction

    function automatic logic [127:0] trl(input logic [31:0] fn, input int nl,
                                         input logic drop, input int ns);
        return {TRL, fn, 16'(nl), 15'b0, drop, 32'(ns)};
    endfunction

    task automatic push(input logic [127:0] m, input logic d, input string t);
        exp_t e;
        e.msg  = m;
        e.done = d;
        e.tag  = t;
        sb.push_back(e);
    endtask

    task automatic drive(input logic f, input logic l, input logic [79:0] d);
        @(negedge clk);
        fval = f;
        lval = l;
        data = d;
        if (ovf_arm && msg_valid) begin
            ovf     = 1'b1;
            ovf_arm = 1'b0;
            ovf_hit = 1'b1;
        end else begin
            ovf = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        fval  = 1'b0;
        lval  = 1'b0;
        ovf   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        fn_m  = 32'd0;
    endtask

    task automatic run_frame(input int nl, input int ns, input int base,
                             input bit en, input bit want, input bit ovf_test,
                             input int gap);
        logic [1279:0] st;
        int            nsmp;
        int            nw;
        nsmp = nl * ns;
        st   = '0;
        for (int i = 0; i < nsmp; i++)
            st[i*80 +: 80] = smp(base + i);
        nw      = (nsmp * 80 + 127) / 128;
        ovf_hit = 1'b0;
        if (want) begin
            push({HDR, fn_m, 64'b0}, 1'b0, "hdr");
            for (int w = 0; w < nw; w++)
                push(st[w*128 +: 128], 1'b0, $sformatf("data%0d", w));
        end
        enable = en;
        drive(1'b1, 1'b0, '0);
        for (int l = 0; l < nl; l++) begin
            for (int s = 0; s < ns; s++) begin
                if (ovf_test && l == 0 && s == 3)
                    ovf_arm = 1'b1;
                drive(1'b1, 1'b1, smp(base + l * ns + s));
                if (!en && l == 0 && s == 1)
                    enable = 1'b1;
            end
            drive(1'b1, 1'b0, '0);
            drive(1'b1, 1'b0, '0);
        end
        ovf_arm = 1'b0;
        if (want) begin
            if (ovf_test && !ovf_hit) begin
                n_tests++;
                n_fail++;
                $display("FAIL ovf_window: got no data word required one");
            end
            push(trl(fn_m, nl, ovf_test && ovf_hit, nsmp), 1'b1, "trl");
            fn_m = fn_m + 32'd1;
        end
        for (int g = 0; g < gap; g++)
            drive(1'b0, 1'b0, '0);
    endtask

    initial begin
        rst_n  = 1'b1;
        enable = 1'b1;
        fval   = 1'b0;
        lval   = 1'b0;
        data   = '0;
        ovf    = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_msg", msg, '0);
        chk("rst_valid", 128'(msg_valid), '0);
        chk("rst_done", 128'(done), '0);
        chk("rst_sticky", 128'(sticky), '0);
        @(negedge clk);
        rst_n = 1'b1;

        run_frame(1, 8, 0, 1'b1, 1'b1, 1'b0, 4);
        run_frame(1, 3, 9, 1'b1, 1'b1, 1'b0, 4);

        pulse_reset();
        run_frame(2, 4, 1, 1'b1, 1'b1, 1'b0, 4);
        run_frame(2, 4, 5, 1'b1, 1'b1, 1'b0, 4);

        run_frame(1, 8, 2, 1'b1, 1'b1, 1'b1, 4);
        chk("sticky_set", 128'(sticky), 128'd1);
        run_frame(1, 4, 3, 1'b1, 1'b1, 1'b0, 4);
        chk("sticky_held", 128'(sticky), 128'd1);

        push({HDR, fn_m, 64'b0}, 1'b0, "rst_hdr");
        enable = 1'b1;
        drive(1'b1, 1'b0, '0);
        drive(1'b1, 1'b1, smp(1));
        drive(1'b1, 1'b1, smp(2));
        @(negedge clk);
        chk("pre_rst_msg_hdr", 128'(msg[127:96]), 128'(HDR));
        rst_n = 1'b0;
        #1;
        chk("midrst_msg", msg, '0);
        chk("midrst_valid", 128'(msg_valid), '0);
        chk("midrst_done", 128'(done), '0);
        chk("midrst_sticky", 128'(sticky), '0);
        @(negedge clk);
        rst_n = 1'b1;
        fn_m  = 32'd0;
        drive(1'b1, 1'b1, smp(3));
        drive(1'b1, 1'b1, smp(4));
        drive(1'b1, 1'b0, '0);
        for (int g = 0; g < 3; g++)
            drive(1'b0, 1'b0, '0);
        run_frame(1, 3, 6, 1'b1, 1'b1, 1'b0, 4);

        pulse_reset();
        run_frame(1, 4, 7, 1'b0, 1'b0, 1'b0, 4);
        run_frame(1, 4, 8, 1'b1, 1'b1, 1'b0, 4);

        run_frame(1, 3, 4, 1'b1, 1'b1, 1'b0, 1);
        run_frame(1, 3, 5, 1'b1, 1'b0, 1'b0, 4);
        run_frame(1, 3, 6, 1'b1, 1'b1, 1'b0, 4);

        for (int g = 0; g < 10; g++)
            drive(1'b0, 1'b0, '0);
        chk("sb_empty", 128'(sb.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
